interconnect_link_arbiter: RTL and testbench
============================================

Name: interconnect_link_arbiter

Overview:
- Round-robin arbiter that shares one physical-plane link between NUM_REQUESTERS local link senders, such as processing-element output channels and a memory port.
- Output is a registered link, one per physical plane, that feeds the interconnect link sender adapter.
- Provides fair, starvation-free access, one packet per cycle of throughput, and one cycle of latency.

Parameters:
- NUM_REQUESTERS, default 4: number of competing input links; minimum 2.
- TAG_WIDTH, default TIA_TAG_WIDTH: packet tag width.
- WORD_WIDTH, default TIA_WORD_WIDTH: packet data width.
- COUNT_WIDTH, default 32: width of the transfer counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_reqs  input  NUM_REQUESTERS  per-requester valid.
- in_acks  output  NUM_REQUESTERS  per-requester accept; one-hot or zero.
- in_tags  input  NUM_REQUESTERS x TAG_WIDTH  per-requester packet tag.
- in_data  input  NUM_REQUESTERS x WORD_WIDTH  per-requester packet data.
- out_req  output  1  registered valid toward the interconnect.
- out_ack  input  1  downstream accept.
- out_tag  output  TAG_WIDTH  registered tag.
- out_data  output  WORD_WIDTH  registered data.
- last_grant  output  clog2(NUM_REQUESTERS)  index of the most recent winner.
- transfer_count  output  COUNT_WIDTH  number of packets accepted from requesters.

Behaviour:
- Handshake rule: a transfer occurs on any edge where req and ack are both 1. A sender holds req, tag and data stable until it is acked. The arbiter holds out_req, out_tag and out_data stable while out_req=1 and out_ack=0.
- State:
  - out_valid, which drives out_req.
  - out_tag and out_data registers.
  - last_grant pointer.
  - transfer_count.
- Reset (async, while reset_n=0):
  - out_req=0, out_tag=0, out_data=0.
  - last_grant=NUM_REQUESTERS-1, so requester 0 has top priority first.
  - transfer_count=0.
  - in_acks=0.
- Load enable: load = !out_valid || out_ack. The buffer is empty or is draining this cycle.
- Arbitration (combinational):
  - The winner is the first requester with in_reqs=1, searching circularly from last_grant+1 and wrapping from NUM_REQUESTERS-1 to 0.
  - in_acks[winner]=1 only when load=1. All other acks are 0.
  - in_acks may depend combinationally on out_ack. No other combinational path from inputs to out_* exists.
- On an edge with load=1 and a winner:
  - out_tag and out_data capture the winner's packet.
  - out_valid becomes 1.
  - last_grant becomes the winner.
  - transfer_count increments, wrapping modulo 2^COUNT_WIDTH.
- On an edge with load=1 and no requests: out_valid becomes 0. Data registers, last_grant and the counter hold.
- On an edge with load=0 (full and stalled): everything holds and no ack is issued.
- Latency: a packet acked at edge N appears on out_* after edge N, one cycle.
- Throughput: with out_ack tied to 1, one packet per cycle.
- Fairness: with k requesters continuously asserting, each is granted exactly once in every k consecutive grants.
- Single requester: the same index may win on consecutive cycles. last_grant only changes on a grant.
- Simultaneous out_ack and new grant: the outgoing packet completes and the new packet replaces it on the same edge with no bubble.
- Reset mid-operation: any buffered packet is discarded. A requester whose req was not acked before reset keeps its packet.
- No request is ever acked while out_valid=1 and out_ack=0.

Decomposition:
- TIA_TAG_WIDTH, TIA_WORD_WIDTH and the packet typedef (tag, data) come from the shared interconnect package/header. A clog2 helper or requester-index typedef belongs there too.
- Sub-module round_robin_arbiter holds the combinational priority search.
  - Parameter: NUM_REQUESTERS.
  - Inputs: requests, last_grant, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Implementation: mask-and-double-priority-encode.
- The top level holds only the output register stage, the pointer and the counter.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with packets pending -> out_req, in_acks and transfer_count go to 0 immediately; after release with in_reqs=4'b1111 and out_ack=1, first grant is requester 0.
- Fairness: in_reqs=4'b1111 held, out_ack=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; out_data matches each sender's word one cycle later; transfer_count=8.
- Backpressure: out_ack=0 for 3 cycles with requester 2 holding tag=5 and data=0xDEAD -> out_* stable, in_acks=0 throughout; on out_ack=1 the transfer completes and the next winner loads on the same edge.
- Skip idle: last_grant=1, in_reqs=4'b0001 -> requester 0 wins via wraparound; then in_reqs=4'b1001 -> requester 3 wins before 0.
- Drain: a single packet, then in_reqs=0 with out_ack=1 -> out_req drops to 0 one cycle after delivery; data registers and last_grant unchanged.
- Counter wrap: with COUNT_WIDTH=4, 17 transfers -> transfer_count=1.

Source files
------------

// File: rtl/interconnect_link_arbiter_pkg.sv
// Shared interconnect definitions for the link arbiter slice.
//   TIA_TAG_WIDTH / TIA_WORD_WIDTH : default packet field widths
//   packet_t                       : one link packet (tag, data)
//   idx_width()                    : width of a requester index
package interconnect_link_arbiter_pkg;

   localparam int TIA_TAG_WIDTH  = 3;
   localparam int TIA_WORD_WIDTH = 32;

   typedef struct packed {
      logic [TIA_TAG_WIDTH-1:0]  tag;
      logic [TIA_WORD_WIDTH-1:0] data;
   } packet_t;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/interconnect_link_arbiter_rr.sv
// Combinational round-robin priority search.
//   requests   : per-requester valid
//   last_grant : index of the previous winner; search starts one above it
//   enable     : gates the grant outputs
//   grant      : one-hot grant (zero when disabled or idle)
//   grant_idx  : index of the winner (meaningful only with any_grant)
//   any_grant  : a grant is being issued this cycle
module round_robin_arbiter
   import interconnect_link_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   localparam int IDX_W = idx_width(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] requests,
   input  logic [IDX_W-1:0]          last_grant,
   input  logic                      enable,
   output logic [NUM_REQUESTERS-1:0] grant,
   output logic [IDX_W-1:0]          grant_idx,
   output logic                      any_grant
);

   logic [NUM_REQUESTERS-1:0] upper_mask;
   logic [NUM_REQUESTERS-1:0] masked;
   logic [IDX_W-1:0]          hi_idx;
   logic [IDX_W-1:0]          lo_idx;

   // Requesters strictly above the last winner get first chance; if none of
   // them is asking, the unmasked encoder provides the wrapped-around winner.
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         upper_mask[i] = (i > int'(last_grant));
      end
   end

   assign masked = requests & upper_mask;

   // Descending scan so the lowest set index is the one left standing.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
         if (masked[i])   hi_idx = IDX_W'(i);
         if (requests[i]) lo_idx = IDX_W'(i);
      end
   end

   assign grant_idx = (|masked) ? hi_idx : lo_idx;
   assign any_grant = enable && (|requests);
   assign grant     = any_grant ? (NUM_REQUESTERS'(1) << grant_idx) : '0;

endmodule

// File: rtl/interconnect_link_arbiter.sv
// Shares one physical-plane link between NUM_REQUESTERS local senders with
// a single registered output stage (one-cycle latency, full throughput).
//   clock, reset_n : system clock, async active-low reset
//   in_reqs/acks   : per-requester valid / accept (accept is one-hot or zero)
//   in_tags/data   : per-requester packet
//   out_req/ack    : registered valid toward the interconnect / its accept
//   out_tag/data   : registered packet
//   last_grant     : index of the most recent winner
//   transfer_count : packets accepted from requesters (wraps)
module interconnect_link_arbiter
   import interconnect_link_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int TAG_WIDTH      = TIA_TAG_WIDTH,
   parameter int WORD_WIDTH     = TIA_WORD_WIDTH,
   parameter int COUNT_WIDTH    = 32,
   localparam int IDX_W = idx_width(NUM_REQUESTERS)
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic [NUM_REQUESTERS-1:0]                 in_reqs,
   output logic [NUM_REQUESTERS-1:0]                 in_acks,
   input  logic [NUM_REQUESTERS-1:0][TAG_WIDTH-1:0]  in_tags,
   input  logic [NUM_REQUESTERS-1:0][WORD_WIDTH-1:0] in_data,
   output logic                                      out_req,
   input  logic                                      out_ack,
   output logic [TAG_WIDTH-1:0]                      out_tag,
   output logic [WORD_WIDTH-1:0]                     out_data,
   output logic [IDX_W-1:0]                          last_grant,
   output logic [COUNT_WIDTH-1:0]                    transfer_count
);

   logic             out_valid;
   logic             load;
   logic             any_grant;
   logic [IDX_W-1:0] grant_idx;

   // Buffer is empty or draining this edge. Reset also blocks acks so no
   // sender believes a packet was taken while the stage is being cleared.
   assign load = !out_valid || out_ack;

   round_robin_arbiter #(
      .NUM_REQUESTERS(NUM_REQUESTERS)
   ) u_rr (
      .requests  (in_reqs),
      .last_grant(last_grant),
      .enable    (load && reset_n),
      .grant     (in_acks),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid      <= 1'b0;
         out_tag        <= '0;
         out_data       <= '0;
         last_grant     <= IDX_W'(NUM_REQUESTERS - 1);
         transfer_count <= '0;
      end else if (load) begin
         if (any_grant) begin
            out_valid      <= 1'b1;
            out_tag        <= in_tags[grant_idx];
            out_data       <= in_data[grant_idx];
            last_grant     <= grant_idx;
            transfer_count <= transfer_count + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_req = out_valid;

endmodule

// File: tb/tb_interconnect_link_arbiter.sv
module tb_interconnect_link_arbiter;
   import interconnect_link_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int CW = 4;

   logic                                  clock;
   logic                                  reset_n;
   logic [N-1:0]                          in_reqs;
   logic [N-1:0]                          in_acks;
   logic [N-1:0][TIA_TAG_WIDTH-1:0]       in_tags;
   logic [N-1:0][TIA_WORD_WIDTH-1:0]      in_data;
   logic                                  out_req;
   logic                                  out_ack;
   logic [TIA_TAG_WIDTH-1:0]              out_tag;
   logic [TIA_WORD_WIDTH-1:0]             out_data;
   logic [1:0]                            last_grant;
   logic [CW-1:0]                         transfer_count;

   interconnect_link_arbiter #(
      .NUM_REQUESTERS(N),
      .TAG_WIDTH     (TIA_TAG_WIDTH),
      .WORD_WIDTH    (TIA_WORD_WIDTH),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_reqs       (in_reqs),
      .in_acks       (in_acks),
      .in_tags       (in_tags),
      .in_data       (in_data),
      .out_req       (out_req),
      .out_ack       (out_ack),
      .out_tag       (out_tag),
      .out_data      (out_data),
      .last_grant    (last_grant),
      .transfer_count(transfer_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Sender side: each requester holds a packet until it is accepted.
   logic    pend_valid [N];
   packet_t pend_pkt   [N];
   logic    ack_drv;

   // Reference model of the output stage.
   logic                      exp_valid;
   logic [TIA_TAG_WIDTH-1:0]  exp_tag;
   logic [TIA_WORD_WIDTH-1:0] exp_data;
   int                        exp_last;
   logic [CW-1:0]             exp_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_valid = 1'b0;
      exp_tag   = '0;
      exp_data  = '0;
      exp_last  = N - 1;
      exp_count = '0;
   endtask

   task automatic new_packet(input int i);
      pend_valid[i]    = 1'b1;
      pend_pkt[i].tag  = TIA_TAG_WIDTH'($urandom_range(0, 7));
      pend_pkt[i].data = $urandom;
   endtask

   task automatic refill_all();
      for (int i = 0; i < N; i++) if (!pend_valid[i]) new_packet(i);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) pend_valid[i] = 1'b0;
   endtask

   // One clock: drive, check everything against the model, then advance it.
   // Entered and left 1 time unit after a rising edge.
   task automatic cyc();
      int           w;
      logic         ld;
      logic [N-1:0] exp_acks;
      for (int i = 0; i < N; i++) begin
         in_reqs[i] = pend_valid[i];
         in_tags[i] = pend_pkt[i].tag;
         in_data[i] = pend_pkt[i].data;
      end
      out_ack = ack_drv;
      #1;
      ld = !exp_valid || ack_drv;
      w  = -1;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (exp_last + k) % N;
         if (w < 0 && pend_valid[idx]) w = idx;
      end
      exp_acks = '0;
      if (ld && w >= 0) exp_acks[w] = 1'b1;
      check("in_acks",        32'(in_acks),        32'(exp_acks));
      check("out_req",        32'(out_req),        32'(exp_valid));
      check("out_tag",        32'(out_tag),        32'(exp_tag));
      check("out_data",       out_data,            exp_data);
      check("last_grant",     32'(last_grant),     32'(exp_last));
      check("transfer_count", 32'(transfer_count), 32'(exp_count));
      @(posedge clock);
      if (ld) begin
         if (w >= 0) begin
            exp_valid     = 1'b1;
            exp_tag       = pend_pkt[w].tag;
            exp_data      = pend_pkt[w].data;
            exp_last      = w;
            exp_count     = exp_count + 1'b1;
            pend_valid[w] = 1'b0;
         end else begin
            exp_valid = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      ack_drv = 1'b1;
      out_ack = 1'b1;
      in_reqs = '0;
      in_tags = '0;
      in_data = '0;
      clear_all();
      model_reset();

      // Reset state, with every requester pending during reset.
      refill_all();
      for (int i = 0; i < N; i++) begin
         in_reqs[i] = 1'b1;
         in_tags[i] = pend_pkt[i].tag;
         in_data[i] = pend_pkt[i].data;
      end
      @(posedge clock); @(posedge clock); #1;
      check("rst_out_req",    32'(out_req),        32'd0);
      check("rst_in_acks",    32'(in_acks),        32'd0);
      check("rst_out_data",   out_data,            32'd0);
      check("rst_last_grant", 32'(last_grant),     32'd3);
      check("rst_count",      32'(transfer_count), 32'd0);
      reset_n = 1'b1;

      // Fairness: all four asserting, grants rotate 0,1,2,3,...
      ack_drv = 1'b1;
      for (int i = 0; i < 8; i++) begin
         refill_all();
         cyc();
         check("fair_grant", 32'(last_grant), 32'(i % 4));
      end
      check("fair_count8", 32'(transfer_count), 32'd8);
      for (int i = 8; i < 17; i++) begin
         refill_all();
         cyc();
         check("fair_grant", 32'(last_grant), 32'(i % 4));
      end
      check("count_wrap17", 32'(transfer_count), 32'd1);

      // Backpressure: stage full, requester 2 waits with a fixed packet.
      clear_all();
      cyc();
      new_packet(1);
      cyc();
      ack_drv = 1'b0;
      pend_valid[2]    = 1'b1;
      pend_pkt[2].tag  = 3'd5;
      pend_pkt[2].data = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp_no_ack", 32'(in_acks), 32'd0);
         check("bp_hold",   32'(last_grant), 32'd1);
      end
      ack_drv = 1'b1;
      cyc();
      check("bp_tag",   32'(out_tag),    32'd5);
      check("bp_data",  out_data,        32'hDEAD);
      check("bp_grant", 32'(last_grant), 32'd2);
      check("bp_valid", 32'(out_req),    32'd1);

      // Drain: no requests, delivery completes, registers hold.
      cyc();
      check("drain_req",   32'(out_req),    32'd0);
      check("drain_tag",   32'(out_tag),    32'd5);
      check("drain_data",  out_data,        32'hDEAD);
      check("drain_grant", 32'(last_grant), 32'd2);

      // Skip idle requesters and wrap around.
      new_packet(1);
      cyc();
      check("skip_g1", 32'(last_grant), 32'd1);
      new_packet(0);
      cyc();
      check("skip_wrap0", 32'(last_grant), 32'd0);
      new_packet(0);
      new_packet(3);
      cyc();
      check("skip_3_before_0", 32'(last_grant), 32'd3);
      cyc();
      check("skip_then_0", 32'(last_grant), 32'd0);

      // Reset mid-operation with a full, stalled stage and senders waiting.
      refill_all();
      ack_drv = 1'b0;
      cyc();
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("midrst_out_req", 32'(out_req),        32'd0);
      check("midrst_in_acks", 32'(in_acks),        32'd0);
      check("midrst_count",   32'(transfer_count), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      ack_drv = 1'b1;
      cyc();
      check("midrst_first_grant", 32'(last_grant), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend_valid[i] && $urandom_range(0, 2) != 0) new_packet(i);
         end
         ack_drv = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
